sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Two-client front end for the byte-wide SDRAM controller; sits directly upstream of it and drives its rd/wr/refresh/addr/din pins.
- Schedules periodic auto-refresh from an internal timer, so refresh has priority and is never starved.
- Arbitrates two byte-access clients (e.g. CPU and PPU/loader) round-robin with a req/ack handshake.
- Returns read data to the owning port.

Parameters:
- FREQ, 54_000_000, clk frequency in Hz.
- REFRESH_US, 15, refresh interval in microseconds; REFRESH_CYCLES = FREQ/1_000_000*REFRESH_US (810 at defaults); timer is 16 bits wide.

Ports:
- clk  in  1  system clock, same clock as the controller's clk.
- resetn  in  1  reset; synchronous, active-low.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  port 0: 1=write, 0=read; stable while req.
- p0_addr  in  23  port 0 byte address; stable while req.
- p0_din  in  8  port 0 write data; stable while req.
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p0_dout  out  8  port 0 read data; valid from ack, held until the next read on port 0 completes.
- p1_req, p1_we, p1_addr, p1_din, p1_ack, p1_dout: same as port 0, for port 1.
- mem_rd  out  1  to controller rd; registered one-cycle pulse.
- mem_wr  out  1  to controller wr; registered one-cycle pulse.
- mem_refresh  out  1  to controller refresh; registered one-cycle pulse.
- mem_addr  out  23  to controller addr; registered.
- mem_din  out  8  to controller din; registered.
- mem_dout  in  8  from controller dout.
- mem_data_ready  in  1  from controller data_ready.
- mem_busy  in  1  from controller busy.

Behaviour:
- Reset values: all acks, mem_rd, mem_wr and mem_refresh are 0. mem_addr, mem_din, p0_dout and p1_dout are 0. FSM goes to S_IDLE, refresh timer to 0, refresh pending count to 0. last_grant is 1, so port 0 wins the first tie.
- Reset mid-operation: state is abandoned immediately and no ack is issued for the in-flight request. The controller shares resetn.
- Refresh timer:
  - Increments every cycle and wraps to 0 at REFRESH_CYCLES-1.
  - On wrap, the 2-bit pending count increments, saturating at 3.
  - Pending decrements when a refresh is issued.
  - If wrap and issue happen in the same cycle, the count is unchanged.
- FSM state S_IDLE: acts only when mem_busy=0. mem_busy stays 1 through controller power-up init, so nothing issues until init is done. Selection priority:
  1. pending>0: issue a refresh.
  2. Otherwise, a single requesting port is granted.
  3. Both ports requesting: grant the port != last_grant.
- On grant: register mem_addr/mem_din from that port and pulse mem_rd (we=0) or mem_wr (we=1). Record the owner and update last_grant, then go to S_ISSUED. Refresh pulses mem_refresh and records no owner.
- FSM state S_ISSUED: the command is visible to the controller this cycle. Deassert all command pulses and go to S_WAIT.
- FSM state S_WAIT:
  - If mem_data_ready=1 and the owner is reading, capture mem_dout into that port's dout.
  - When mem_busy=0, pulse the owner's ack for one cycle (none for refresh) and go to S_IDLE.
- Ack masking: a port's req is ignored during the cycle its ack is high. A req still high in the following cycle is a new request.
- Latency with controller defaults (T_RCD=1, CAS=2, T_WR=2, T_RP=1, T_RC=4), counted from the grant edge:
  - Read: ack registered 5 edges later.
  - Write: ack registered 6 edges later.
  - Refresh: back in S_IDLE 5 edges later.
- At most one command is outstanding at a time; there is no pipelining.
- Requests arriving in any state other than S_IDLE wait. They are never dropped.

Test Plan:
- Reset, then hold mem_busy=1 for 20 cycles with p0_req=1 -> no mem_rd/mem_wr/mem_refresh pulse. Release busy -> mem_rd pulses once with p0's address.
- p0 write to addr 0x000123 with din 0xA5, then p0 read of 0x000123 against the controller model -> write ack 6 edges after grant; read ack 5 edges after grant; p0_dout = 0xA5.
- p0_req and p1_req held simultaneously with continuous re-requests -> grants alternate p0, p1, p0, p1; each ack lands on the correct port; no duplicate grant in an ack cycle.
- FREQ=1_000_000, REFRESH_US=15, no client traffic -> mem_refresh pulses every 15 cycles once idle.
- Stall the arbiter in S_WAIT across 4 timer wraps -> pending saturates at 3; exactly 3 back-to-back refreshes are issued before any pending client request.
- Assert resetn=0 during S_WAIT of a p1 read -> next cycle: no p1_ack, FSM in S_IDLE, timer and pending are 0, all outputs at reset values.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port round-robin front end for the byte-wide SDRAM controller, with timer-driven auto-refresh.
// One command outstanding at a time; clients hold req until a one-cycle ack, and refresh takes the next idle slot.
module sdram_arbiter #(
    parameter int FREQ       = 54_000_000,
    parameter int REFRESH_US = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [22:0] p0_addr,
    input  logic [7:0]  p0_din,
    output logic        p0_ack,
    output logic [7:0]  p0_dout,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [22:0] p1_addr,
    input  logic [7:0]  p1_din,
    output logic        p1_ack,
    output logic [7:0]  p1_dout,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_refresh,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        mem_data_ready,
    input  logic        mem_busy
);

    localparam int          REFRESH_CYCLES = FREQ / 1_000_000 * REFRESH_US;
    localparam logic [15:0] REFRESH_LAST   = 16'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUED = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  pending_q, pending_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;          // port index of the in-flight access
    logic        owner_vld_q, owner_vld_d;  // low while a refresh is in flight
    logic        owner_rd_q, owner_rd_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mem_refresh_q, mem_refresh_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_din_q, mem_din_d;
    logic        p0_ack_q, p0_ack_d;
    logic        p1_ack_q, p1_ack_d;
    logic [7:0]  p0_dout_q, p0_dout_d;
    logic [7:0]  p1_dout_q, p1_dout_d;

    logic p0_live, p1_live;
    logic timer_wrap, refresh_issue;
    logic grant_p1, grant_we;

    // A req seen during its own ack cycle is the tail of the finished access.
    assign p0_live = p0_req && !p0_ack_q;
    assign p1_live = p1_req && !p1_ack_q;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        owner_vld_d   = owner_vld_q;
        owner_rd_d    = owner_rd_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        p0_dout_d     = p0_dout_q;
        p1_dout_d     = p1_dout_q;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        mem_refresh_d = 1'b0;
        p0_ack_d      = 1'b0;
        p1_ack_d      = 1'b0;
        refresh_issue = 1'b0;

        timer_wrap = (timer_q == REFRESH_LAST);
        timer_d    = timer_wrap ? 16'd0 : timer_q + 16'd1;

        grant_p1 = p1_live && (!p0_live || !last_grant_q);
        grant_we = grant_p1 ? p1_we : p0_we;

        case (state_q)
            S_IDLE: begin
                if (!mem_busy) begin
                    if (pending_q != 2'd0) begin
                        refresh_issue = 1'b1;
                        mem_refresh_d = 1'b1;
                        owner_vld_d   = 1'b0;
                        owner_rd_d    = 1'b0;
                        state_d       = S_ISSUED;
                    end else if (p0_live || p1_live) begin
                        owner_d      = grant_p1;
                        owner_vld_d  = 1'b1;
                        owner_rd_d   = !grant_we;
                        last_grant_d = grant_p1;
                        mem_addr_d   = grant_p1 ? p1_addr : p0_addr;
                        mem_din_d    = grant_p1 ? p1_din : p0_din;
                        mem_rd_d     = !grant_we;
                        mem_wr_d     = grant_we;
                        state_d      = S_ISSUED;
                    end
                end
            end
            S_ISSUED: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_data_ready && owner_vld_q && owner_rd_q) begin
                    if (owner_q) p1_dout_d = mem_dout;
                    else         p0_dout_d = mem_dout;
                end
                if (!mem_busy) begin
                    if (owner_vld_q) begin
                        p0_ack_d = !owner_q;
                        p1_ack_d = owner_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pending_d = pending_q;
        case ({timer_wrap, refresh_issue})
            2'b10:   pending_d = (pending_q == 2'd3) ? 2'd3 : pending_q + 2'd1;
            2'b01:   pending_d = pending_q - 2'd1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            timer_q       <= 16'd0;
            pending_q     <= 2'd0;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            owner_vld_q   <= 1'b0;
            owner_rd_q    <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_refresh_q <= 1'b0;
            mem_addr_q    <= 23'd0;
            mem_din_q     <= 8'd0;
            p0_ack_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
            p0_dout_q     <= 8'd0;
            p1_dout_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            owner_vld_q   <= owner_vld_d;
            owner_rd_q    <= owner_rd_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            mem_refresh_q <= mem_refresh_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            p0_ack_q      <= p0_ack_d;
            p1_ack_q      <= p1_ack_d;
            p0_dout_q     <= p0_dout_d;
            p1_dout_q     <= p1_dout_d;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_refresh = mem_refresh_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign p0_ack      = p0_ack_q;
    assign p1_ack      = p1_ack_q;
    assign p0_dout     = p0_dout_q;
    assign p1_dout     = p1_dout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a default-rate instance behind a small controller model, plus a fast-refresh
// instance with no client traffic. Directed transaction table followed by hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_sdram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        p0_req, p0_we, p0_ack;
    logic [22:0] p0_addr;
    logic [7:0]  p0_din, p0_dout;
    logic        p1_req, p1_we, p1_ack;
    logic [22:0] p1_addr;
    logic [7:0]  p1_din, p1_dout;
    logic        mem_rd, mem_wr, mem_refresh;
    logic [22:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_data_ready, mem_busy;

    logic        init_busy, stall, ctl_busy, ctl_is_rd;
    logic [2:0]  ctl_cnt;
    logic [7:0]  ctl_addr;
    logic [7:0]  mem_arr [0:255];

    assign mem_busy = init_busy | stall | ctl_busy;

    sdram_arbiter u_dut (
        .clk(clk), .resetn(resetn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din),
        .p0_ack(p0_ack), .p0_dout(p0_dout),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
        .p1_ack(p1_ack), .p1_dout(p1_dout),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_data_ready(mem_data_ready), .mem_busy(mem_busy)
    );

    // Controller model: read busy 3 cycles, write 4, refresh 3; data_ready on the cycle busy drops.
    always @(posedge clk) begin
        if (!resetn) begin
            ctl_busy       <= 1'b0;
            ctl_cnt        <= 3'd0;
            ctl_is_rd      <= 1'b0;
            ctl_addr       <= 8'd0;
            mem_dout       <= 8'd0;
            mem_data_ready <= 1'b0;
            for (int i = 0; i < 256; i++) mem_arr[i] <= 8'h00;
        end else begin
            mem_data_ready <= 1'b0;
            if (mem_rd || mem_wr || mem_refresh) begin
                ctl_busy  <= 1'b1;
                ctl_cnt   <= mem_wr ? 3'd4 : 3'd3;
                ctl_is_rd <= mem_rd;
                ctl_addr  <= mem_addr[7:0];
                if (mem_wr) mem_arr[mem_addr[7:0]] <= mem_din;
            end else if (ctl_cnt != 3'd0) begin
                ctl_cnt <= ctl_cnt - 3'd1;
                if (ctl_cnt == 3'd1) begin
                    ctl_busy <= 1'b0;
                    if (ctl_is_rd) begin
                        mem_data_ready <= 1'b1;
                        mem_dout       <= mem_arr[ctl_addr];
                    end
                end
            end
        end
    end

    logic        f_resetn, f_zero, f_p0_ack, f_p1_ack, f_rd, f_wr, f_refresh, f_busy, f_ready;
    logic [22:0] f_zaddr, f_addr;
    logic [7:0]  f_zbyte, f_din, f_dout, f_d0, f_d1;
    logic [2:0]  f_cnt;

    sdram_arbiter #(.FREQ(1_000_000), .REFRESH_US(15)) u_fast (
        .clk(clk), .resetn(f_resetn),
        .p0_req(f_zero), .p0_we(f_zero), .p0_addr(f_zaddr), .p0_din(f_zbyte),
        .p0_ack(f_p0_ack), .p0_dout(f_d0),
        .p1_req(f_zero), .p1_we(f_zero), .p1_addr(f_zaddr), .p1_din(f_zbyte),
        .p1_ack(f_p1_ack), .p1_dout(f_d1),
        .mem_rd(f_rd), .mem_wr(f_wr), .mem_refresh(f_refresh),
        .mem_addr(f_addr), .mem_din(f_din), .mem_dout(f_dout),
        .mem_data_ready(f_ready), .mem_busy(f_busy)
    );

    always @(posedge clk) begin
        if (!f_resetn) begin
            f_cnt  <= 3'd0;
            f_busy <= 1'b0;
        end else if (f_refresh) begin
            f_cnt  <= 3'd3;
            f_busy <= 1'b1;
        end else if (f_cnt != 3'd0) begin
            f_cnt <= f_cnt - 3'd1;
            if (f_cnt == 3'd1) f_busy <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_total++;
        $display("FAIL %s: got no event, required one within the cycle bound", name);
    endtask

    task automatic wait_cmd(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_rd || mem_wr) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout(name);
    endtask

    task automatic wait_ack(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout(name);
    endtask

    task automatic drive(input bit port, input bit we, input logic [22:0] addr, input logic [7:0] din);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_din = din;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_din = din;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; p0_req = 1'b0; p1_req = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [22:0] addr;
        logic [7:0]  din;
        int          lat;
        logic [7:0]  d0;
        logic [7:0]  d1;
    } vec_t;

    vec_t vecs [7];

    initial begin
        bit ok;
        int t0, n, n_ref, t_rel, n_fref, n_fbad;
        int ftimes [5];

        vecs[0] = '{1'b0, 1'b1, 23'h000123, 8'hA5, 6, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 23'h000123, 8'h00, 5, 8'hA5, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 23'h7FFFFF, 8'h3C, 6, 8'hA5, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 23'h7FFFFF, 8'h00, 5, 8'hA5, 8'h3C};
        vecs[4] = '{1'b0, 1'b1, 23'h000000, 8'hFF, 6, 8'hA5, 8'h3C};
        vecs[5] = '{1'b1, 1'b0, 23'h000123, 8'h00, 5, 8'hA5, 8'hA5};
        vecs[6] = '{1'b0, 1'b0, 23'h000000, 8'h00, 5, 8'hFF, 8'hA5};

        resetn = 1'b0; f_resetn = 1'b0; init_busy = 1'b0; stall = 1'b0;
        f_zero = 1'b0; f_zaddr = 23'd0; f_zbyte = 8'd0; f_dout = 8'd0; f_ready = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 23'd0; p0_din = 8'd0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 23'd0; p1_din = 8'd0;
        repeat (3) @(negedge clk);

        chk("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
        chk("rst_cmds", {29'd0, mem_refresh, mem_wr, mem_rd}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_din", mem_din, 32'd0);
        chk("rst_douts", {p1_dout, p0_dout}, 32'd0);

        // Fast-refresh instance: first refresh 16 edges after release, then every 15.
        f_resetn = 1'b1;
        t_rel = cyc; n_fref = 0; n_fbad = 0;
        for (int i = 0; i < 120 && n_fref < 5; i++) begin
            @(negedge clk);
            if (f_refresh) begin
                ftimes[n_fref] = cyc;
                n_fref++;
            end
            if (f_rd || f_wr || f_p0_ack || f_p1_ack) n_fbad++;
        end
        if (n_fref < 5) fail_timeout("fast_refresh");
        else begin
            chk("fast_first_refresh", ftimes[0] - t_rel, 16);
            for (int j = 1; j < 5; j++)
                chk($sformatf("fast_refresh_gap%0d", j), ftimes[j] - ftimes[j-1], 15);
        end
        chk("fast_no_client", n_fbad, 0);
        chk("fast_quiet_regs", {f_addr[7:0], f_din, f_d0, f_d1}, 32'd0);

        // Controller still initialising: nothing may issue until busy drops.
        @(negedge clk);
        resetn = 1'b0; init_busy = 1'b1;
        drive(1'b0, 1'b0, 23'h000456, 8'h00);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_rd || mem_wr || mem_refresh) n++;
        end
        chk("init_no_cmd", n, 0);
        init_busy = 1'b0;
        wait_cmd("init_grant", ok);
        if (ok) begin
            t0 = cyc;
            chk("init_rd", {30'd0, mem_wr, mem_rd}, 32'd1);
            chk("init_addr", mem_addr, 32'h000456);
            n = 0;
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (mem_rd) n++;
                if (p0_ack) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) fail_timeout("init_ack");
            else begin
                chk("init_single_rd", n, 0);
                chk("init_ack_lat", cyc - t0, 5);
            end
        end
        p0_req = 1'b0;

        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(vecs[k].port, vecs[k].we, vecs[k].addr, vecs[k].din);
            wait_cmd($sformatf("v%0d_grant", k), ok);
            if (ok) begin
                t0 = cyc;
                chk($sformatf("v%0d_addr", k), mem_addr, vecs[k].addr);
                chk($sformatf("v%0d_cmd", k), {30'd0, mem_wr, mem_rd}, vecs[k].we ? 32'd2 : 32'd1);
                if (vecs[k].we) chk($sformatf("v%0d_din", k), mem_din, vecs[k].din);
                wait_ack($sformatf("v%0d_ack", k), ok);
                if (ok) begin
                    chk($sformatf("v%0d_lat", k), cyc - t0, vecs[k].lat);
                    chk($sformatf("v%0d_ack_port", k), {30'd0, p1_ack, p0_ack}, vecs[k].port ? 32'd2 : 32'd1);
                    chk($sformatf("v%0d_p0_dout", k), p0_dout, vecs[k].d0);
                    chk($sformatf("v%0d_p1_dout", k), p1_dout, vecs[k].d1);
                end
            end
            p0_req = 1'b0;
            p1_req = 1'b0;
        end

        // Reset lands while a p1 read is waiting on the controller.
        drive(1'b1, 1'b0, 23'h7FFFFF, 8'h00);
        wait_cmd("rstmid_grant", ok);
        @(negedge clk);
        chk("rstmid_in_wait", u_dut.state_q, 32'd2);
        resetn = 1'b0;
        @(negedge clk);
        chk("rstmid_no_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
        chk("rstmid_state", u_dut.state_q, 32'd0);
        chk("rstmid_timer_pend", {14'd0, u_dut.pending_q, u_dut.timer_q}, 32'd0);
        chk("rstmid_cmds", {29'd0, mem_refresh, mem_wr, mem_rd}, 32'd0);
        chk("rstmid_addr_din", {1'b0, mem_addr, mem_din}, 32'd0);
        chk("rstmid_douts", {p1_dout, p0_dout}, 32'd0);
        p1_req = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Both ports hammer continuously: port 0 first, then strict alternation.
        do_reset();
        drive(1'b0, 1'b0, 23'h000010, 8'h00);
        drive(1'b1, 1'b0, 23'h000020, 8'h00);
        for (int g = 0; g < 4; g++) begin
            wait_cmd($sformatf("rr%0d_grant", g), ok);
            if (ok) begin
                chk($sformatf("rr%0d_addr", g), mem_addr, (g % 2 == 0) ? 32'h10 : 32'h20);
                wait_ack($sformatf("rr%0d_ack", g), ok);
                if (ok) chk($sformatf("rr%0d_ack_port", g), {30'd0, p1_ack, p0_ack}, (g % 2 == 0) ? 32'd1 : 32'd2);
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;

        // Stall in S_WAIT across four timer wraps, then drain the saturated refresh backlog.
        do_reset();
        drive(1'b0, 1'b0, 23'h000300, 8'h00);
        drive(1'b1, 1'b0, 23'h000400, 8'h00);
        wait_cmd("stall_grant", ok);
        chk("stall_first_addr", mem_addr, 32'h300);
        stall = 1'b1;
        repeat (3300) @(negedge clk);
        chk("stall_pending", u_dut.pending_q, 32'd3);
        chk("stall_state", u_dut.state_q, 32'd2);
        stall = 1'b0;
        n_ref = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (p0_ack) p0_req = 1'b0;
            if (mem_refresh) n_ref++;
            if (mem_rd || mem_wr) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout("stall_client_grant");
        else begin
            chk("stall_refresh_count", n_ref, 3);
            chk("stall_p1_addr", mem_addr, 32'h400);
            wait_ack("stall_p1_ack", ok);
            if (ok) chk("stall_p1_ack_port", {30'd0, p1_ack, p0_ack}, 32'd2);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
